// File: rtl/lpif_rx_x2_strobe_align.sv
// Two-channel LPIF receive aligner: measures strobe skew, delays the early channel,
// qualifies lock over coincident strobes and reassembles the 75-bit upstream word.
module lpif_rx_x2_strobe_align #(
    parameter int unsigned MAX_SKEW   = 3,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic        clk_rd,
    input  logic        rst_rd_n,
    input  logic        rx_online,
    input  logic [39:0] rx_phy0,
    input  logic [39:0] rx_phy1,
    output logic [74:0] rx_upstream_data,
    output logic        rx_upstream_valid,
    output logic        rx_stb_userbit,
    output logic        rx_mrk_userbit,
    output logic        rx_aligned,
    output logic [3:0]  rx_skew,
    output logic [7:0]  rx_align_err_cnt
);

    typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [39:0] dl0_q [MAX_SKEW];
    logic [39:0] dl0_d [MAX_SKEW];
    logic [39:0] dl1_q [MAX_SKEW];
    logic [39:0] dl1_d [MAX_SKEW];
    logic [39:0] tap0 [MAX_SKEW+1];
    logic [39:0] tap1 [MAX_SKEW+1];
    logic [39:0] sel0, sel1, a0, a1;

    logic        early_q, early_d;   // applied: 1 = ch1 is early
    logic [2:0]  skew_q, skew_d;
    logic        meas_q, meas_d;     // channel seen first while measuring
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  lock_q, lock_d;
    logic [7:0]  err_q, err_d;
    logic [74:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        aligned_q, aligned_d;
    logic        stb_q, stb_d;
    logic        mrk_q, mrk_d;

    logic        raw0, raw1, as0, as1, late_raw, early_raw;
    logic [3:0]  cnt_p1;
    logic [3:0]  lock_p1;
    logic        unused_bits;

    // Tap 0 is the live input; taps 1..MAX_SKEW are the registered history.
    always_comb begin
        tap0[0]  = rx_phy0;
        tap1[0]  = rx_phy1;
        dl0_d[0] = rx_phy0;
        dl1_d[0] = rx_phy1;
        for (int unsigned k = 1; k <= MAX_SKEW; k++) begin
            tap0[k] = dl0_q[k-1];
            tap1[k] = dl1_q[k-1];
        end
        for (int unsigned k = 1; k < MAX_SKEW; k++) begin
            dl0_d[k] = dl0_q[k-1];
            dl1_d[k] = dl1_q[k-1];
        end
    end

    always_comb begin
        sel0 = '0;
        sel1 = '0;
        for (int unsigned k = 0; k <= MAX_SKEW; k++) begin
            if (skew_q == 3'(k)) begin
                sel0 = tap0[k];
                sel1 = tap1[k];
            end
        end
        a0 = early_q ? tap0[0] : sel0;
        a1 = early_q ? sel1 : tap1[0];
        unused_bits = ^a1[39:38];
    end

    always_comb begin
        raw0      = rx_phy0[1];
        raw1      = rx_phy1[1];
        as0       = a0[1];
        as1       = a1[1];
        late_raw  = meas_q ? raw0 : raw1;
        early_raw = meas_q ? raw1 : raw0;
        cnt_p1    = {1'b0, cnt_q} + 4'd1;
        lock_p1   = lock_q + 4'd1;

        state_d = state_q;
        early_d = early_q;
        skew_d  = skew_q;
        meas_d  = meas_q;
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        err_d   = err_q;

        if (!rx_online) begin
            state_d = SEARCH;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (raw0 && raw1) begin
                        skew_d  = '0;
                        early_d = 1'b0;
                        lock_d  = '0;
                        state_d = CHECK;
                    end else if (raw0 ^ raw1) begin
                        meas_d  = raw1;
                        cnt_d   = '0;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (cnt_p1 > 4'(MAX_SKEW)) begin
                        state_d = SEARCH;
                    end else if (late_raw) begin
                        skew_d  = cnt_p1[2:0];
                        early_d = meas_q;
                        lock_d  = '0;
                        state_d = CHECK;
                    end else if (early_raw) begin
                        state_d = SEARCH;
                    end else begin
                        cnt_d = cnt_p1[2:0];
                    end
                end
                CHECK: begin
                    if (as0 && as1) begin
                        lock_d = lock_p1;
                        if (lock_p1 == 4'(LOCK_COUNT)) state_d = LOCKED;
                    end else if (as0 ^ as1) begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (as0 ^ as1) begin
                        state_d = SEARCH;
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Valid only for words sampled while lock was already held and kept.
        valid_d   = (state_q == LOCKED) && (state_d == LOCKED);
        aligned_d = valid_d;
        data_d    = {a1[37:2], a1[0], a0[38:2], a0[0]};
        stb_d     = a0[1];
        mrk_d     = a0[39];
    end

    always_ff @(posedge clk_rd) begin
        if (!rst_rd_n) begin
            state_q   <= SEARCH;
            for (int unsigned k = 0; k < MAX_SKEW; k++) begin
                dl0_q[k] <= '0;
                dl1_q[k] <= '0;
            end
            early_q   <= 1'b0;
            skew_q    <= '0;
            meas_q    <= 1'b0;
            cnt_q     <= '0;
            lock_q    <= '0;
            err_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            aligned_q <= 1'b0;
            stb_q     <= 1'b0;
            mrk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            for (int unsigned k = 0; k < MAX_SKEW; k++) begin
                dl0_q[k] <= dl0_d[k];
                dl1_q[k] <= dl1_d[k];
            end
            early_q   <= early_d;
            skew_q    <= skew_d;
            meas_q    <= meas_d;
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            err_q     <= err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            aligned_q <= aligned_d;
            stb_q     <= stb_d;
            mrk_q     <= mrk_d;
        end
    end

    always_comb begin
        rx_upstream_data  = data_q;
        rx_upstream_valid = valid_q;
        rx_stb_userbit    = stb_q;
        rx_mrk_userbit    = mrk_q;
        rx_aligned        = aligned_q;
        rx_skew           = {early_q, skew_q};
        rx_align_err_cnt  = err_q;
    end

endmodule

// File: tb/tb_lpif_rx_x2_strobe_align.sv
// Directed bench for lpif_rx_x2_strobe_align: skewed strobe streams, lock/loss,
// online drop, mid-lock reset and error-counter saturation.
module tb_lpif_rx_x2_strobe_align;

    localparam int MAXS = 3;
    localparam int LCK  = 4;

    logic        clk = 1'b0;
    logic        rst_rd_n;
    logic        rx_online;
    logic [39:0] rx_phy0, rx_phy1;
    logic [74:0] rx_upstream_data;
    logic        rx_upstream_valid, rx_stb_userbit, rx_mrk_userbit, rx_aligned;
    logic [3:0]  rx_skew;
    logic [7:0]  rx_align_err_cnt;

    always #5 clk = ~clk;

    lpif_rx_x2_strobe_align #(.MAX_SKEW(MAXS), .LOCK_COUNT(LCK)) dut (
        .clk_rd            (clk),
        .rst_rd_n          (rst_rd_n),
        .rx_online         (rx_online),
        .rx_phy0           (rx_phy0),
        .rx_phy1           (rx_phy1),
        .rx_upstream_data  (rx_upstream_data),
        .rx_upstream_valid (rx_upstream_valid),
        .rx_stb_userbit    (rx_stb_userbit),
        .rx_mrk_userbit    (rx_mrk_userbit),
        .rx_aligned        (rx_aligned),
        .rx_skew           (rx_skew),
        .rx_align_err_cnt  (rx_align_err_cnt)
    );

    int checks = 0;
    int errors = 0;
    int c, d0, d1, dl, drop_mode;
    bit auto_chk, seen_valid;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [74:0] payf(input int n);
        logic [31:0] x, y;
        if (n == 40) return 75'h1234_5678_9ABC_DEF0_123;
        x = 32'(n) * 32'h9E37_79B9;
        y = (32'(n) * 32'h85EB_CA6B) ^ 32'h0BAD_F00D;
        return {x, y, 11'(n)};
    endfunction

    function automatic bit dropped(input int n);
        case (drop_mode)
            1:       return (n == 48) || (n == 144);
            2:       return (n > 0) && (n % 48 == 0);
            default: return 1'b0;
        endcase
    endfunction

    // Transmitter-side packing of one payload onto the two PHY channels.
    function automatic logic [39:0] w0f(input int n);
        logic [74:0] p;
        p = payf(n);
        return {(n % 16 == 0), p[37:1], (n % 8 == 0), p[0]};
    endfunction

    function automatic logic [39:0] w1f(input int n);
        logic [74:0] p;
        p = payf(n);
        return {(n % 16 == 0), 1'b1, p[74:39], ((n % 8 == 0) && !dropped(n)), p[38]};
    endfunction

    task automatic tick();
        int n0, n1;
        n0 = c - d0;
        n1 = c - d1;
        rx_phy0 = (n0 >= 0) ? w0f(n0) : '0;
        rx_phy1 = (n1 >= 0) ? w1f(n1) : '0;
        @(posedge clk);
        #1;
        if (rx_upstream_valid) seen_valid = 1'b1;
        if (auto_chk && rx_upstream_valid)
            check("data", 80'(rx_upstream_data), 80'(payf(c - dl)));
        c++;
    endtask

    task automatic run_to(input int upto);
        while (c <= upto) tick();
    endtask

    task automatic do_reset();
        rst_rd_n  = 1'b0;
        rx_online = 1'b1;
        rx_phy0   = '0;
        rx_phy1   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_rd_n = 1'b1;
    endtask

    task automatic start(input int a, input int b, input int mode);
        d0 = a;
        d1 = b;
        dl = (a > b) ? a : b;
        drop_mode  = mode;
        c          = 0;
        seen_valid = 1'b0;
        auto_chk   = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},    80'(rx_upstream_data), 80'(0));
        check({tag, "_valid"},   80'(rx_upstream_valid), 80'(0));
        check({tag, "_stb"},     80'(rx_stb_userbit), 80'(0));
        check({tag, "_mrk"},     80'(rx_mrk_userbit), 80'(0));
        check({tag, "_aligned"}, 80'(rx_aligned), 80'(0));
        check({tag, "_skew"},    80'(rx_skew), 80'(0));
        check({tag, "_err"},     80'(rx_align_err_cnt), 80'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        d0 = 0; d1 = 0; dl = 0; drop_mode = 0; c = 0; auto_chk = 1'b0; seen_valid = 1'b0;
        do_reset();
        check_reset_outputs("rst");

        // Zero skew, lock, single loss, online drops, mid-lock reset.
        start(0, 0, 1);
        run_to(31);
        check("a_prelock_valid", 80'(rx_upstream_valid), 80'(0));
        run_to(32);
        check("a_4th_stb",       80'(rx_stb_userbit), 80'(1));
        check("a_4th_mrk",       80'(rx_mrk_userbit), 80'(1));
        check("a_4th_valid",     80'(rx_upstream_valid), 80'(0));
        check("a_4th_data",      80'(rx_upstream_data), 80'(payf(32)));
        run_to(33);
        check("a_lock_valid",    80'(rx_upstream_valid), 80'(1));
        check("a_lock_aligned",  80'(rx_aligned), 80'(1));
        check("a_skew",          80'(rx_skew), 80'(4'b0000));
        run_to(40);
        check("a_special",       80'(rx_upstream_data), 80'(75'h1234_5678_9ABC_DEF0_123));
        check("a_special_valid", 80'(rx_upstream_valid), 80'(1));
        run_to(47);
        check("a_prelos_valid",  80'(rx_upstream_valid), 80'(1));
        run_to(48);
        check("a_los_valid",     80'(rx_upstream_valid), 80'(0));
        check("a_los_aligned",   80'(rx_aligned), 80'(0));
        check("a_los_err",       80'(rx_align_err_cnt), 80'(1));
        check("a_los_data",      80'(rx_upstream_data), 80'(payf(48)));
        run_to(88);
        check("a_relock_early",  80'(rx_upstream_valid), 80'(0));
        run_to(89);
        check("a_relock_valid",  80'(rx_upstream_valid), 80'(1));
        run_to(99);
        rx_online = 1'b0;
        run_to(100);
        check("a_off_valid",     80'(rx_upstream_valid), 80'(0));
        check("a_off_aligned",   80'(rx_aligned), 80'(0));
        check("a_off_err",       80'(rx_align_err_cnt), 80'(1));
        run_to(101);
        rx_online = 1'b1;
        run_to(136);
        check("a_on_early",      80'(rx_upstream_valid), 80'(0));
        run_to(137);
        check("a_on_valid",      80'(rx_upstream_valid), 80'(1));
        check("a_on_err",        80'(rx_align_err_cnt), 80'(1));
        run_to(143);
        rx_online = 1'b0;
        run_to(144);
        check("a_offlos_err",    80'(rx_align_err_cnt), 80'(1));
        check("a_offlos_valid",  80'(rx_upstream_valid), 80'(0));
        rx_online = 1'b1;
        run_to(185);
        check("a_relock2_valid", 80'(rx_upstream_valid), 80'(1));
        run_to(189);
        rst_rd_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        rst_rd_n = 1'b1;

        // ch1 lags ch0 by MAX_SKEW.
        do_reset();
        start(0, 3, 0);
        run_to(35);
        check("b_prelock_valid", 80'(rx_upstream_valid), 80'(0));
        run_to(36);
        check("b_lock_valid",    80'(rx_upstream_valid), 80'(1));
        check("b_skew",          80'(rx_skew), 80'(4'b0011));
        check("b_data",          80'(rx_upstream_data), 80'(payf(33)));
        run_to(80);
        check("b_hold_valid",    80'(rx_upstream_valid), 80'(1));

        // ch0 lags ch1 by 2.
        do_reset();
        start(2, 0, 0);
        run_to(34);
        check("c_prelock_valid", 80'(rx_upstream_valid), 80'(0));
        run_to(35);
        check("c_lock_valid",    80'(rx_upstream_valid), 80'(1));
        check("c_skew",          80'(rx_skew), 80'(4'b1010));
        check("c_data",          80'(rx_upstream_data), 80'(payf(33)));
        run_to(42);
        check("c_special",       80'(rx_upstream_data), 80'(75'h1234_5678_9ABC_DEF0_123));

        // Skew one beyond MAX_SKEW is never corrected.
        do_reset();
        start(0, 4, 0);
        run_to(199);
        check("d_never_valid",   80'(seen_valid), 80'(0));
        check("d_aligned",       80'(rx_aligned), 80'(0));
        check("d_err",           80'(rx_align_err_cnt), 80'(0));
        check("d_skew",          80'(rx_skew), 80'(0));

        // Repeated losses saturate the error counter.
        do_reset();
        start(0, 0, 2);
        run_to(48 * 254);
        check("e_err_254",       80'(rx_align_err_cnt), 80'(254));
        run_to(48 * 255);
        check("e_err_255",       80'(rx_align_err_cnt), 80'(255));
        run_to(48 * 300);
        check("e_err_sat",       80'(rx_align_err_cnt), 80'(255));
        check("e_los_valid",     80'(rx_upstream_valid), 80'(0));
        run_to(48 * 300 + 41);
        check("e_relock_valid",  80'(rx_upstream_valid), 80'(1));
        check("e_relock_err",    80'(rx_align_err_cnt), 80'(255));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpif_rx_x2_strobe_align.md
# lpif_rx_x2_strobe_align

Slave-side receive aligner for the two-channel, full-rate, Gen1 LPIF transport. Each 40-bit PHY channel carries 38 data bits, a persistent strobe at bit 1 and a marker at bit 39. The block measures inter-channel skew from the strobe, delays the early channel, and qualifies lock over repeated coincident strobes. It then reassembles the 75-bit upstream word and presents it with a valid qualifier to the logic link.

## Interface
Parameters:
- MAX_SKEW, 3, largest correctable channel-to-channel skew in clk_rd cycles (1..7)
- LOCK_COUNT, 4, coincident aligned strobes required to declare lock (1..15)

Ports (one clock; reset is synchronous and active-low):
- clk_rd  input  1  receive clock
- rst_rd_n  input  1  synchronous active-low reset
- rx_online  input  1  link enable; low forces the FSM to SEARCH
- rx_phy0  input  40  PHY channel 0
- rx_phy1  input  40  PHY channel 1
- rx_upstream_data  output  75  reassembled word
- rx_upstream_valid  output  1  data qualifier; high only in LOCKED
- rx_stb_userbit  output  1  aligned channel-0 strobe
- rx_mrk_userbit  output  1  aligned channel-0 marker
- rx_aligned  output  1  FSM in LOCKED
- rx_skew  output  4  {early_is_ch1, skew[2:0]} currently applied
- rx_align_err_cnt  output  8  saturating count of lock losses

## Operation
- Delay lines: per channel, MAX_SKEW+1 deep shift register of the 40-bit word, updated every cycle in all states.
  - Aligned late channel = tap 0.
  - Aligned early channel = tap skew.
- Bit map (aligned ch0 = a0, ch1 = a1):
  - data[0]=a0[0]; data[37:1]=a0[38:2]
  - data[38]=a1[0]; data[74:39]=a1[37:2]
  - a1[38] is ignored.
  - rx_stb_userbit=a0[1]; rx_mrk_userbit=a0[39].
- FSM states: SEARCH, MEASURE, CHECK, LOCKED.
- SEARCH:
  - Both raw strobes (rx_phyN[1]) high in the same cycle: skew=0, go to CHECK.
  - Exactly one raw strobe high: latch the early channel, clear skew counter to 0, go to MEASURE.
- MEASURE:
  - Counter increments each cycle.
  - Late-channel raw strobe arrives with counter+1 <= MAX_SKEW: skew=counter+1, go to CHECK.
  - Early channel strobes again first, or counter+1 > MAX_SKEW: return to SEARCH (no error count).
- CHECK:
  - Skew is applied; lock counter is cleared on entry.
  - Aligned strobes both high: lock counter +1; reaching LOCK_COUNT goes to LOCKED.
  - Aligned strobes differ: go to SEARCH.
- LOCKED:
  - Aligned strobes differ: go to SEARCH and increment rx_align_err_cnt, saturating at 255.
  - Otherwise remain in LOCKED.
- rx_online low: next state SEARCH from any state; the counter and skew do not change until reacquisition.
- skew and early-channel select change only on the MEASURE/SEARCH→CHECK transition. They are held through CHECK and LOCKED.

## Timing
- All outputs are registered.
- Reset values: data 0, valid 0, stb 0, mrk 0, aligned 0, skew 0, err_cnt 0; delay lines 0; FSM in SEARCH.
- Latency:
  - Late channel rx_phy → rx_upstream_data: 1 cycle.
  - Early channel: 1+skew cycles.
- rx_upstream_valid and rx_aligned rise on the cycle after the LOCK_COUNT-th coincident aligned strobe is sampled. That strobe's word itself is not valid.
- On a mismatch in LOCKED, valid falls on the next cycle, in the same cycle err_cnt updates. The mismatching word is output with valid=0.
- rx_upstream_data is driven every cycle regardless of valid.
- Simultaneous events:
  - rx_online low overrides a mismatch: no error is counted.
  - Reset mid-lock clears everything in one cycle, including err_cnt.
- Skew equal to MAX_SKEW is correctable; MAX_SKEW+1 never leaves SEARCH/MEASURE.

## Test plan
- Zero skew, strobe every 8 cycles, LOCK_COUNT=4 → rx_skew=0. rx_aligned rises 1 cycle after the 4th strobe. Data 75'h1234_5678_9ABC_DEF0_123 appears 1 cycle after its PHY cycle with valid=1.
- ch1 lags ch0 by 3 (MAX_SKEW=3) → rx_skew=4'b0_011. Output words match the ch0/ch1 halves sent in the same transmitter cycle.
- ch0 lags ch1 by 2 → rx_skew=4'b1_010, with correct reassembly.
- Skew of 4 with MAX_SKEW=3 → never aligned, valid stays 0, err_cnt stays 0.
- Locked, then drop one ch1 strobe → valid and aligned fall the next cycle, err_cnt=1, relock after 4 strobes. Repeat 300 losses → err_cnt saturates at 255.
- Locked, then deassert rx_online for 2 cycles → state SEARCH, err_cnt unchanged. Assert rst_rd_n=0 for one cycle mid-lock → all outputs at reset values on the next cycle.
